// File: rtl/store_result_checker.sv
// store_result_checker
// Watches the CPU data-memory store bus and judges a program run without
// simulator-side printing. A small table of expected (address, data) stores
// is loaded while idle; one or more entries may be marked as the terminating
// store. During a run every store is compared against the table, counted and
// logged into a FIFO, while a watchdog bounds the run length.

module store_result_checker #(
    parameter  int DW       = 64,
    parameter  int AW       = 64,
    parameter  int NEXP     = 4,
    parameter  int TIMEOUT  = 48,
    parameter  int LOGDEPTH = 8,
    localparam int IW       = (NEXP > 1) ? $clog2(NEXP) : 1,
    localparam int LW       = 2 + AW + DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     memwrite,
    input  logic [AW-1:0]  dataadr,
    input  logic [DW-1:0]  writedata,
    input  logic           cfg_we,
    input  logic [IW-1:0]  cfg_idx,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [DW-1:0]  cfg_data,
    input  logic           cfg_final,
    input  logic           start,
    input  logic           log_ready,
    output logic           log_valid,
    output logic [LW-1:0]  log_data,
    output logic [NEXP-1:0] hit_mask,
    output logic [15:0]    cycles,
    output logic [15:0]    store_count,
    output logic           done,
    output logic           pass,
    output logic           timeout,
    output logic           overflow
);

    localparam int PW = (LOGDEPTH > 1) ? $clog2(LOGDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_VAL   = CW'(LOGDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Expected-store table. Address/data storage needs no reset because an
    // entry only participates in matching once its valid bit is set.
    logic [AW-1:0]   exp_addr [NEXP];
    logic [DW-1:0]   exp_data [NEXP];
    logic [NEXP-1:0] exp_final;
    logic [NEXP-1:0] exp_valid;

    // Store log FIFO; the occupancy lives in its own counter so that full and
    // empty are unambiguous when the pointers are equal.
    logic [LW-1:0]   log_mem [LOGDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   log_count;

    logic            in_run;
    logic            run_start;
    logic            cfg_ok;
    logic            store_seen;
    logic [NEXP-1:0] match;
    logic            final_hit;
    logic [15:0]     cycles_inc;
    logic            timeout_hit;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;

    // Compare the current bus transaction against every valid table entry
    always_comb begin
        match = '0;
        for (int i = 0; i < NEXP; i++) begin
            match[i] = exp_valid[i] && (dataadr == exp_addr[i]) && (writedata == exp_data[i]);
        end
    end

    // Derive the per-cycle run events: sampled store, terminating hit, watchdog expiry, FIFO handshake
    always_comb begin
        in_run      = (state == RUN);
        cfg_ok      = cfg_we && (state != RUN) && (int'(cfg_idx) < NEXP);
        store_seen  = in_run && (memwrite != 2'b00);
        final_hit   = store_seen && ((match & exp_final) != '0);
        cycles_inc  = cycles + 16'd1;
        timeout_hit = in_run && (cycles_inc == TIMEOUT_VAL);
        fifo_full   = (log_count == DEPTH_VAL);
        pop         = log_valid && log_ready;
        push        = store_seen && (!fifo_full || pop);
        drop        = store_seen && fifo_full && !pop;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a terminating store and the watchdog both end a run
    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                if (final_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Table valid/final flags; writes are only honoured outside a run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid <= '0;
            exp_final <= '0;
        end else if (cfg_ok) begin
            exp_valid[cfg_idx] <= 1'b1;
            exp_final[cfg_idx] <= cfg_final;
        end
    end

    // Table address/data storage
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            exp_addr[cfg_idx] <= cfg_addr;
            exp_data[cfg_idx] <= cfg_data;
        end
    end

    // Run status: match flags, cycle and store counters, and the verdict bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_mask    <= '0;
            cycles      <= '0;
            store_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else if (run_start) begin
            hit_mask    <= '0;
            cycles      <= '0;
            store_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else if (in_run) begin
            cycles <= cycles_inc;
            if (store_seen) begin
                hit_mask <= hit_mask | match;
                if (store_count != 16'hFFFF) begin
                    store_count <= store_count + 16'd1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (final_hit) begin
                pass <= 1'b1;
                done <= 1'b1;
            end else if (timeout_hit) begin
                timeout <= 1'b1;
                done    <= 1'b1;
            end
        end
    end

    // Log FIFO pointers and occupancy; starting a run empties the log
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
        end else if (run_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                log_count <= log_count + CW'(1);
            end else if (pop && !push) begin
                log_count <= log_count - CW'(1);
            end
        end
    end

    // Log FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            log_mem[wr_ptr] <= {memwrite, dataadr, writedata};
        end
    end

    assign log_valid = (log_count != '0);
    assign log_data  = log_mem[rd_ptr];

endmodule

// File: tb/tb_store_result_checker.sv
// Directed self-checking bench for store_result_checker (default parameters).
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.

module tb_store_result_checker;

    logic          clk;
    logic          reset;
    logic [1:0]    memwrite;
    logic [63:0]   dataadr;
    logic [63:0]   writedata;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [63:0]   cfg_addr;
    logic [63:0]   cfg_data;
    logic          cfg_final;
    logic          start;
    logic          log_ready;
    logic          log_valid;
    logic [129:0]  log_data;
    logic [3:0]    hit_mask;
    logic [15:0]   cycles;
    logic [15:0]   store_count;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          overflow;

    int vectors;
    int miscompares;

    store_result_checker dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_final(cfg_final),
        .start(start),
        .log_ready(log_ready),
        .log_valid(log_valid),
        .log_data(log_data),
        .hit_mask(hit_mask),
        .cycles(cycles),
        .store_count(store_count),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .overflow(overflow)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [63:0] addr,
                             input logic [63:0] data, input logic fin);
        cfg_idx   = idx;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_final = fin;
        cfg_we    = 1'b1;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic store(input logic [1:0] mw, input logic [63:0] addr, input logic [63:0] data);
        memwrite  = mw;
        dataadr   = addr;
        writedata = data;
        tick(1);
        memwrite  = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_log_valid: got %0b want 0", log_valid); end
        vectors++; if (hit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_hit_mask: got %b want 0000", hit_mask); end
        vectors++; if (cycles !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_cycles: got %0d want 0", cycles); end
        vectors++; if (store_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_store_count: got %0d want 0", store_count); end
        vectors++; if ({done, pass, timeout, overflow} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_flags: got %b want 0000", {done, pass, timeout, overflow}); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_pass();
        logic [129:0] exp_head;
        do_reset();
        cfg_write(2'd0, 64'd100, 64'd7, 1'b1);
        start_run();
        tick(9);
        vectors++; if (cycles !== 16'd9) begin miscompares++; $display("[TB] FAIL pass_pre_cycles: got %0d want 9", cycles); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_pre_done: got %0b want 0", done); end
        store(2'b01, 64'd100, 64'd7);
        vectors++; if ({done, pass, timeout} !== 3'b110) begin miscompares++; $display("[TB] FAIL pass_flags: got %b want 110", {done, pass, timeout}); end
        vectors++; if (hit_mask !== 4'b0001) begin miscompares++; $display("[TB] FAIL pass_hit_mask: got %b want 0001", hit_mask); end
        vectors++; if (cycles !== 16'd10) begin miscompares++; $display("[TB] FAIL pass_cycles: got %0d want 10", cycles); end
        vectors++; if (store_count !== 16'd1) begin miscompares++; $display("[TB] FAIL pass_store_count: got %0d want 1", store_count); end
        exp_head = {2'b01, 64'd100, 64'd7};
        vectors++; if (log_valid !== 1'b1 || log_data !== exp_head) begin miscompares++; $display("[TB] FAIL pass_log_head: got %0b/%h want 1/%h", log_valid, log_data, exp_head); end
        tick(3);
        store(2'b01, 64'd100, 64'd7);
        vectors++; if (cycles !== 16'd10) begin miscompares++; $display("[TB] FAIL done_cycles_hold: got %0d want 10", cycles); end
        vectors++; if (store_count !== 16'd1) begin miscompares++; $display("[TB] FAIL done_store_ignored: got %0d want 1", store_count); end
    endtask

    task automatic test_nonfinal();
        logic [129:0] exp_log [3];
        exp_log[0] = {2'b01, 64'd80, 64'd1};
        exp_log[1] = {2'b10, 64'd84, 64'd3};
        exp_log[2] = {2'b11, 64'd128, 64'd7};
        do_reset();
        cfg_write(2'd0, 64'd80, 64'd1, 1'b0);
        cfg_write(2'd1, 64'd128, 64'd7, 1'b1);
        start_run();
        store(2'b01, 64'd80, 64'd1);
        vectors++; if (hit_mask !== 4'b0001 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL nf_first: got hit=%b done=%0b want 0001/0", hit_mask, done); end
        store(2'b10, 64'd84, 64'd3);
        store(2'b11, 64'd128, 64'd7);
        vectors++; if (hit_mask !== 4'b0011) begin miscompares++; $display("[TB] FAIL nf_hit_mask: got %b want 0011", hit_mask); end
        vectors++; if (store_count !== 16'd3) begin miscompares++; $display("[TB] FAIL nf_store_count: got %0d want 3", store_count); end
        vectors++; if ({done, pass, timeout} !== 3'b110) begin miscompares++; $display("[TB] FAIL nf_flags: got %b want 110", {done, pass, timeout}); end
        vectors++; if (cycles !== 16'd3) begin miscompares++; $display("[TB] FAIL nf_cycles: got %0d want 3", cycles); end
        log_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (log_valid !== 1'b1 || log_data !== exp_log[i]) begin miscompares++; $display("[TB] FAIL nf_log%0d: got %0b/%h want 1/%h", i, log_valid, log_data, exp_log[i]); end
            tick(1);
        end
        log_ready = 1'b0;
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nf_log_empty: got %0b want 0", log_valid); end
    endtask

    task automatic test_watchdog();
        do_reset();
        cfg_write(2'd0, 64'd100, 64'd7, 1'b1);
        start_run();
        store(2'b01, 64'd100, 64'h8000_0000_0000_0007);
        tick(46);
        vectors++; if (cycles !== 16'd47 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_pre: got cycles=%0d done=%0b want 47/0", cycles, done); end
        vectors++; if (hit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL wd_msb_nomatch: got %b want 0000", hit_mask); end
        tick(1);
        vectors++; if ({done, pass, timeout} !== 3'b101) begin miscompares++; $display("[TB] FAIL wd_flags: got %b want 101", {done, pass, timeout}); end
        vectors++; if (cycles !== 16'd48) begin miscompares++; $display("[TB] FAIL wd_cycles: got %0d want 48", cycles); end
    endtask

    task automatic test_tie();
        do_reset();
        cfg_write(2'd0, 64'd100, 64'd7, 1'b1);
        start_run();
        tick(47);
        store(2'b01, 64'd100, 64'd7);
        vectors++; if ({done, pass, timeout} !== 3'b110) begin miscompares++; $display("[TB] FAIL tie_flags: got %b want 110", {done, pass, timeout}); end
        vectors++; if (cycles !== 16'd48) begin miscompares++; $display("[TB] FAIL tie_cycles: got %0d want 48", cycles); end
    endtask

    task automatic test_overflow();
        logic [129:0] exp_entry;
        do_reset();
        log_ready = 1'b0;
        start_run();
        for (int i = 0; i < 10; i++) begin
            store(2'b01, 64'(1000 + i), 64'(3 * i));
            if (i == 7) begin
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_at_full: got %0b want 0", overflow); end
            end
            if (i == 8) begin
                vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_first_drop: got %0b want 1", overflow); end
            end
        end
        vectors++; if (store_count !== 16'd10 || overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_totals: got count=%0d ovf=%0b want 10/1", store_count, overflow); end
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_entry = {2'b01, 64'(1000 + i), 64'(3 * i)};
            vectors++; if (log_valid !== 1'b1 || log_data !== exp_entry) begin miscompares++; $display("[TB] FAIL ovf_log%0d: got %0b/%h want 1/%h", i, log_valid, log_data, exp_entry); end
            tick(1);
        end
        log_ready = 1'b0;
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_log_empty: got %0b want 0", log_valid); end
    endtask

    task automatic test_back_to_back();
        logic [129:0] exp_entry;
        do_reset();
        log_ready = 1'b0;
        start_run();
        for (int i = 0; i < 8; i++) begin
            store(2'b01, 64'(i), 64'(i + 100));
        end
        log_ready = 1'b1;
        store(2'b01, 64'd8, 64'd108);
        log_ready = 1'b0;
        vectors++; if (overflow !== 1'b0 || store_count !== 16'd9) begin miscompares++; $display("[TB] FAIL b2b_full_pushpop: got ovf=%0b count=%0d want 0/9", overflow, store_count); end
        log_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            exp_entry = {2'b01, 64'(i), 64'(i + 100)};
            vectors++; if (log_valid !== 1'b1 || log_data !== exp_entry) begin miscompares++; $display("[TB] FAIL b2b_log%0d: got %0b/%h want 1/%h", i, log_valid, log_data, exp_entry); end
            tick(1);
        end
        log_ready = 1'b0;
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_log_empty: got %0b want 0", log_valid); end
    endtask

    task automatic test_abort();
        do_reset();
        cfg_write(2'd0, 64'd100, 64'd7, 1'b1);
        start_run();
        cfg_write(2'd0, 64'd200, 64'd9, 1'b0);
        store(2'b01, 64'd100, 64'd7);
        vectors++; if (pass !== 1'b1 || hit_mask !== 4'b0001) begin miscompares++; $display("[TB] FAIL abort_cfg_ignored: got pass=%0b hit=%b want 1/0001", pass, hit_mask); end
        start_run();
        vectors++; if ({done, pass, timeout, overflow} !== 4'b0000 || hit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL restart_flags: got %b hit=%b want 0000/0000", {done, pass, timeout, overflow}, hit_mask); end
        vectors++; if (cycles !== 16'd0 || store_count !== 16'd0 || log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_counts: got cyc=%0d cnt=%0d lv=%0b want 0/0/0", cycles, store_count, log_valid); end
        tick(3);
        start_run();
        vectors++; if (cycles !== 16'd4) begin miscompares++; $display("[TB] FAIL start_in_run: got %0d want 4", cycles); end
        store(2'b01, 64'd5, 64'd5);
        reset = 1'b1;
        #2;
        vectors++; if (cycles !== 16'd0 || store_count !== 16'd0 || log_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_counts: got cyc=%0d cnt=%0d lv=%0b want 0/0/0", cycles, store_count, log_valid); end
        vectors++; if ({done, pass, timeout, overflow} !== 4'b0000) begin miscompares++; $display("[TB] FAIL abort_flags: got %b want 0000", {done, pass, timeout, overflow}); end
        reset = 1'b0;
        tick(2);
        vectors++; if (cycles !== 16'd0) begin miscompares++; $display("[TB] FAIL abort_idle: got cycles=%0d want 0", cycles); end
        start_run();
        store(2'b01, 64'd100, 64'd7);
        tick(1);
        vectors++; if (pass !== 1'b0 || done !== 1'b0 || hit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL abort_table_cleared: got pass=%0b done=%0b hit=%b want 0/0/0000", pass, done, hit_mask); end
        vectors++; if (store_count !== 16'd1 || cycles !== 16'd2) begin miscompares++; $display("[TB] FAIL abort_rerun: got cnt=%0d cyc=%0d want 1/2", store_count, cycles); end
    endtask

    // Test sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        memwrite    = 2'b00;
        dataadr     = '0;
        writedata   = '0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_addr    = '0;
        cfg_data    = '0;
        cfg_final   = 1'b0;
        start       = 1'b0;
        log_ready   = 1'b0;
        test_reset();
        test_pass();
        test_nonfinal();
        test_watchdog();
        test_tie();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_result_checker.md
Name: store_result_checker

Overview:
- Synthesizable checker on the CPU data-memory store bus (memwrite/dataadr/writedata) at the top-level boundary.
- Holds a small table of expected (address, data) stores and marks one entry as the terminating store.
- Runs a watchdog cycle counter, logs every observed store into a FIFO, and reports pass/timeout status.
- Lets benches and FPGA builds judge a program run without $display-based checking.

Parameters:
- DW, 64, store data width.
- AW, 64, store address width.
- NEXP, 4, number of expected-store table entries.
- TIMEOUT, 48, RUN cycles allowed before timeout (1..65535).
- LOGDEPTH, 8, store log FIFO depth (power of 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  2  CPU store strobe; nonzero = store this cycle.
- dataadr  input  AW  store address.
- writedata  input  DW  store data.
- cfg_we  input  1  write one expected-table entry.
- cfg_idx  input  $clog2(NEXP)  entry index.
- cfg_addr  input  AW  expected address.
- cfg_data  input  DW  expected data.
- cfg_final  input  1  entry is the terminating store.
- start  input  1  one-cycle pulse to begin a run.
- log_ready  input  1  consumer accepts the log head.
- log_valid  output  1  log FIFO non-empty.
- log_data  output  2+AW+DW  {memwrite, dataadr, writedata} at the FIFO head.
- hit_mask  output  NEXP  sticky per-entry match flags.
- cycles  output  16  RUN cycle count.
- store_count  output  16  stores seen this run, saturating at 16'hFFFF.
- done  output  1  run finished.
- pass  output  1  terminating store observed.
- timeout  output  1  watchdog expired.
- overflow  output  1  sticky; a store was dropped because the log was full.

Behaviour:
- Reset (async):
  - State goes to IDLE; all table valid bits clear.
  - All outputs 0: hit_mask, cycles, store_count, done, pass, timeout, overflow, log_valid.
  - FIFO is emptied.
- States: IDLE, RUN, DONE.
- Configuration:
  - cfg_we is accepted only in IDLE or DONE. It writes addr/data/final and sets that entry's valid bit.
  - cfg_we in RUN is ignored.
  - Entries never written stay invalid and never match.
- IDLE/DONE -> RUN on start:
  - Clears hit_mask, cycles, store_count, done, pass, timeout, overflow and the FIFO.
  - The table is preserved.
  - start while in RUN is ignored.
- Store sampling in RUN, on each rising edge with memwrite != 0:
  - An entry matches when it is valid and dataadr == cfg_addr and writedata == cfg_data (full-width compare).
  - All matching entries set their hit_mask bit in the same cycle.
  - store_count increments.
  - The store is pushed to the FIFO. If the FIFO is full, the store is dropped and overflow is set.
- cycles increments by 1 every RUN cycle, including the first.
- RUN -> DONE conditions:
  - A store matches an entry with final=1: pass=1, done=1.
  - Otherwise, cycles reaches TIMEOUT (the registered value after increment equals TIMEOUT): timeout=1, done=1.
  - pass, timeout and done are registered and visible the cycle after the causing edge.
- Simultaneous events:
  - Final-match in the same cycle cycles reaches TIMEOUT: pass wins, timeout stays 0.
  - If no valid entry has final=1, the run can only end by timeout.
- In DONE, stores are neither counted, logged nor matched; cycles holds its value.
- Log FIFO:
  - log_data is valid whenever log_valid=1.
  - Pop occurs on log_valid & log_ready.
  - A simultaneous push and pop when full is accepted with no drop.
  - Pointers wrap modulo LOGDEPTH; the count is held in a separate counter.
  - The FIFO stays readable in DONE.
- Reset asserted mid-RUN aborts the run immediately to IDLE and clears the table.

Test Plan:
- Pass on terminating store:
  - Stimulus: entry0 = (100, 7, final); start; store 100/7 on RUN cycle 10.
  - Response: next cycle pass=1, done=1, hit_mask=0001, cycles=10, store_count=1.
- Non-final entry plus terminating entry:
  - Stimulus: entry0 = (80, 1, nonfinal), entry1 = (128, 7, final); stores 80/1, 84/3, then 128/7.
  - Response: hit_mask=0011, store_count=3, pass=1; log pops return the three stores in order.
- Watchdog:
  - Stimulus: TIMEOUT=48, no matching store.
  - Response: after the 48th RUN cycle timeout=1, done=1, pass=0, cycles=48.
- Tie between pass and timeout:
  - Stimulus: final store lands on the edge where cycles becomes 48.
  - Response: pass=1, timeout=0.
- Log overflow:
  - Stimulus: log_ready=0, 10 stores with LOGDEPTH=8.
  - Response: overflow=1, store_count=10, exactly 8 entries readable, first 8 in order.
- Ignored inputs and abort:
  - Stimulus: cfg_we during RUN targeting entry0; then reset pulse mid-RUN.
  - Response: the table is unchanged by the RUN-time cfg_we. After reset: state IDLE, all outputs 0, entries invalid, and a later start with store 100/7 does not pass.
